// File: rtl/cache_types.sv
// Shared cache-subsystem types: line/address widths and the memory arbiter state encoding.
package cache_types;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        GRANT_I,
        GRANT_D_RD,
        GRANT_D_WR,
        DONE
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Purpose: shares one line-memory port between I-cache and D-cache, D first, I-cache starvation bounded.
// Latency: request sampled in IDLE at N, pmem request from N+1 until pmem_resp, resp passed through same cycle, one DONE bubble.
// Backpressure: one line in flight; requests are held by the caches until their resp pulse, losers simply wait.
module mem_arbiter
    import cache_types::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output line_t             i_mem_rdata,
    output logic              i_mem_resp,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  line_t             d_mem_wdata,
    output line_t             d_mem_rdata,
    output logic              d_mem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output line_t             pmem_wdata,
    input  line_t             pmem_rdata,
    input  logic              pmem_resp
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    line_t             wdata_q, wdata_d;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                // A saturated counter hands the next slot to a waiting I-cache regardless of D traffic.
                if (i_mem_read && (starve_q == CNT_MAX)) begin
                    state_d = GRANT_I;
                    addr_d  = i_mem_address;
                end else if (d_mem_write) begin
                    state_d = GRANT_D_WR;
                    addr_d  = d_mem_address;
                    wdata_d = d_mem_wdata;
                end else if (d_mem_read) begin
                    state_d = GRANT_D_RD;
                    addr_d  = d_mem_address;
                end else if (i_mem_read) begin
                    state_d = GRANT_I;
                    addr_d  = i_mem_address;
                end

                if (state_d == GRANT_I) begin
                    starve_d = '0;
                end else if (state_d != IDLE) begin
                    if (!i_mem_read) begin
                        starve_d = '0;
                    end else if (starve_q != CNT_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            GRANT_I, GRANT_D_RD, GRANT_D_WR: begin
                if (pmem_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign pmem_read    = (state_q == GRANT_I) || (state_q == GRANT_D_RD);
    assign pmem_write   = (state_q == GRANT_D_WR);
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_mem_resp   = (state_q == GRANT_I) && pmem_resp;
    assign d_mem_resp   = ((state_q == GRANT_D_RD) || (state_q == GRANT_D_WR)) && pmem_resp;
    assign i_mem_rdata  = i_mem_resp ? pmem_rdata : '0;
    assign d_mem_rdata  = d_mem_resp ? pmem_rdata : '0;

    // Simulation-only notices for protocol abuse by neighbours; no effect on behaviour.
    always @(posedge clk) begin
        if (rst && (state_q == IDLE) && d_mem_read && d_mem_write) begin
            $warning("mem_arbiter: d_mem_read and d_mem_write both high, write takes priority");
        end
        if (rst && pmem_resp && ((state_q == IDLE) || (state_q == DONE))) begin
            $warning("mem_arbiter: pmem_resp outside a grant, ignored");
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random cache traffic against a transaction-level model.
module tb_mem_arbiter;
    import cache_types::*;

    localparam int STARVE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_mem_read;
    logic [31:0] i_mem_address;
    line_t       i_mem_rdata;
    logic        i_mem_resp;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [31:0] d_mem_address;
    line_t       d_mem_wdata;
    line_t       d_mem_rdata;
    logic        d_mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    line_t       pmem_wdata;
    line_t       pmem_rdata;
    logic        pmem_resp;

    mem_arbiter #(.STARVE_MAX(STARVE)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_mem_read   (i_mem_read),
        .i_mem_address(i_mem_address),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_resp   (i_mem_resp),
        .d_mem_read   (d_mem_read),
        .d_mem_write  (d_mem_write),
        .d_mem_address(d_mem_address),
        .d_mem_wdata  (d_mem_wdata),
        .d_mem_rdata  (d_mem_rdata),
        .d_mem_resp   (d_mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef enum {M_IDLE, M_BUSY, M_BUBBLE} mph_t;
    typedef enum {W_I, W_DR, W_DW} who_t;
    typedef struct { who_t who; logic [31:0] addr; } grant_t;

    mph_t        ph = M_IDLE;
    who_t        cur_who = W_I;
    logic [31:0] cur_addr = '0;
    line_t       cur_wdata = '0;
    int          streak = 0;
    grant_t      glog[$];
    line_t       ref_mem  [logic [31:0]];
    line_t       pmem_arr [logic [31:0]];

    int i_resp_cnt = 0, d_resp_cnt = 0;
    bit i_seen = 0, d_seen = 0, chk_en = 0, rand_en = 0;
    int lat_fixed = -1, mem_wait = 0;
    bit mem_active = 0;
    bit exp_i, exp_d, m_busy;
    line_t exp_rd;

    function automatic line_t init_line(input logic [31:0] a);
        return {8{a ^ 32'hC0DE_F00D}};
    endfunction

    function automatic line_t ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    function automatic line_t arr_rd(input logic [31:0] a);
        return pmem_arr.exists(a) ? pmem_arr[a] : init_line(a);
    endfunction

    task automatic model_grant(input who_t w, input logic [31:0] a, input bit i_waiting);
        grant_t g;
        g.who = w; g.addr = a;
        glog.push_back(g);
        cur_who = w; cur_addr = a; cur_wdata = d_mem_wdata;
        ph = M_BUSY;
        if (w == W_I)       streak = 0;
        else if (i_waiting) streak = (streak + 1 > STARVE) ? STARVE : streak + 1;
        else                streak = 0;
    endtask

    always @(negedge clk) begin
        m_busy = (ph == M_BUSY);
        exp_i  = m_busy && (cur_who == W_I) && pmem_resp;
        exp_d  = m_busy && (cur_who != W_I) && pmem_resp;
        exp_rd = (cur_who == W_DW) ? pmem_rdata : ref_rd(cur_addr);
        if (chk_en) begin
            check_eq("pmem_read",  256'(pmem_read),  256'(m_busy && cur_who != W_DW));
            check_eq("pmem_write", 256'(pmem_write), 256'(m_busy && cur_who == W_DW));
            check_eq("i_mem_resp", 256'(i_mem_resp), 256'(exp_i));
            check_eq("d_mem_resp", 256'(d_mem_resp), 256'(exp_d));
            check_eq("i_mem_rdata", i_mem_rdata, exp_i ? exp_rd : '0);
            check_eq("d_mem_rdata", d_mem_rdata, exp_d ? exp_rd : '0);
            if (m_busy) begin
                check_eq("pmem_address", 256'(pmem_address), 256'(cur_addr));
                if (cur_who == W_DW) check_eq("pmem_wdata", pmem_wdata, cur_wdata);
            end
        end
        if (!rst) begin
            ph = M_IDLE;
            streak = 0;
        end else begin
            case (ph)
                M_IDLE: begin
                    if (i_mem_read && streak >= STARVE) model_grant(W_I, i_mem_address, 1'b1);
                    else if (d_mem_write)               model_grant(W_DW, d_mem_address, i_mem_read);
                    else if (d_mem_read)                model_grant(W_DR, d_mem_address, i_mem_read);
                    else if (i_mem_read)                model_grant(W_I, i_mem_address, 1'b1);
                end
                M_BUSY: begin
                    if (pmem_resp) begin
                        if (cur_who == W_DW) ref_mem[cur_addr] = cur_wdata;
                        ph = M_BUBBLE;
                    end
                end
                default: ph = M_IDLE;
            endcase
        end
        i_seen = i_mem_resp;
        d_seen = d_mem_resp;
        if (i_mem_resp) i_resp_cnt++;
        if (d_mem_resp) d_resp_cnt++;
    end

    // One clock of stimulus: caches drop after their resp, memory responds, optional random traffic.
    task automatic tick();
        @(posedge clk);
        #1;
        if (i_seen) i_mem_read = 1'b0;
        if (d_seen) begin
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
        end
        pmem_resp  = 1'b0;
        pmem_rdata = {8{$urandom}};
        if (pmem_read || pmem_write) begin
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_wait   = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
            end
            if (mem_wait == 0) begin
                pmem_resp = 1'b1;
                if (pmem_read) pmem_rdata = arr_rd(pmem_address);
                else           pmem_arr[pmem_address] = pmem_wdata;
                mem_active = 1'b0;
            end else begin
                mem_wait--;
            end
        end else begin
            mem_active = 1'b0;
        end
        if (rand_en) begin
            d_mem_wdata = {8{$urandom}};
            if (!i_mem_read && !i_seen && $urandom_range(0, 3) == 0) begin
                i_mem_read    = 1'b1;
                i_mem_address = 32'($urandom_range(0, 15)) << 5;
            end
            if (!d_mem_read && !d_mem_write && !d_seen && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) d_mem_write = 1'b1;
                else                           d_mem_read  = 1'b1;
                d_mem_address = 32'($urandom_range(0, 15)) << 5;
            end
        end
    endtask

    task automatic wait_resp(input bit is_d, input int target, input int budget);
        int n = 0;
        while (((is_d ? d_resp_cnt : i_resp_cnt) < target) && (n < budget)) begin
            tick();
            n++;
        end
        check_eq(is_d ? "d_resp_count" : "i_resp_count",
                 256'(is_d ? d_resp_cnt : i_resp_cnt), 256'(target));
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        rst = 1'b0;
        i_mem_read = 1'b0; i_mem_address = '0;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;

        // Reset state
        tick();
        chk_en = 1'b1;
        tick();
        check_eq("rst pmem_read",    256'(pmem_read),    '0);
        check_eq("rst pmem_write",   256'(pmem_write),   '0);
        check_eq("rst pmem_address", 256'(pmem_address), '0);
        check_eq("rst pmem_wdata",   pmem_wdata,         '0);
        check_eq("rst i_mem_resp",   256'(i_mem_resp),   '0);
        check_eq("rst d_mem_resp",   256'(d_mem_resp),   '0);
        check_eq("rst i_mem_rdata",  i_mem_rdata,        '0);
        check_eq("rst d_mem_rdata",  d_mem_rdata,        '0);
        rst = 1'b1;
        tick();

        // Lone I read with zero memory latency: request and response in the cycle after sampling
        ref_mem[32'h60]  = {32{8'hA5}};
        pmem_arr[32'h60] = {32{8'hA5}};
        lat_fixed = 0;
        i_mem_read = 1'b1; i_mem_address = 32'h60;
        tick();
        #1;
        check_eq("lone_i pmem_read",    256'(pmem_read),    256'(1));
        check_eq("lone_i pmem_address", 256'(pmem_address), 256'(32'h60));
        check_eq("lone_i i_mem_resp",   256'(i_mem_resp),   256'(1));
        check_eq("lone_i i_mem_rdata",  i_mem_rdata,        {32{8'hA5}});
        wait_resp(1'b0, 1, 20);

        // Simultaneous I and D reads: D first
        lat_fixed = -1;
        glog.delete();
        i_mem_read = 1'b1; i_mem_address = 32'h100;
        d_mem_read = 1'b1; d_mem_address = 32'h200;
        wait_resp(1'b1, 1, 40);
        wait_resp(1'b0, 2, 40);
        check_eq("simul grants", 256'(glog.size()), 256'(2));
        check_eq("simul first",  256'(glog[0].who),  256'(W_DR));
        check_eq("simul second", 256'(glog[1].who),  256'(W_I));
        check_eq("simul i_addr", 256'(glog[1].addr), 256'(32'h100));

        // Writeback: latched wdata must survive d_mem_wdata changing after the grant
        lat_fixed = 3;
        d_mem_write = 1'b1; d_mem_address = 32'h340; d_mem_wdata = {8{32'h1234_5678}};
        tick();
        d_mem_wdata = {8{32'hFFFF_0000}};
        wait_resp(1'b1, 2, 40);
        check_eq("wb stored line", arr_rd(32'h340), {8{32'h1234_5678}});
        i_mem_read = 1'b1; i_mem_address = 32'h340;
        wait_resp(1'b0, 3, 40);

        // Starvation: I held while D re-requests back to back
        lat_fixed = 1;
        glog.delete();
        cnt = 0;
        i_mem_read = 1'b1; i_mem_address = 32'h180;
        d_mem_read = 1'b1; d_mem_address = 32'h400;
        while (glog.size() < 6 && cnt < 200) begin
            tick();
            cnt++;
            if (!d_mem_read && glog.size() < 6) begin
                d_mem_read    = 1'b1;
                d_mem_address = 32'h400 + 32'(cnt) * 32;
            end
        end
        repeat (12) tick();
        check_eq("starve grants", 256'(glog.size()), 256'(6));
        for (int k = 0; k < 6; k++) begin
            check_eq("starve order", 256'(glog[k].who), 256'((k == 4) ? W_I : W_DR));
        end

        // Reset while a D read waits on memory
        lat_fixed = 10;
        d_mem_read = 1'b1; d_mem_address = 32'h200;
        tick();
        tick();
        cnt = d_resp_cnt;
        rst = 1'b0;
        tick();
        #1;
        check_eq("midrst pmem_read",    256'(pmem_read),    '0);
        check_eq("midrst pmem_address", 256'(pmem_address), '0);
        check_eq("midrst d_mem_resp",   256'(d_mem_resp),   '0);
        d_mem_read = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check_eq("midrst no resp", 256'(d_resp_cnt), 256'(cnt));

        // Spurious memory response while idle
        pmem_resp = 1'b1; pmem_rdata = {8{32'hBAD0_BAD0}};
        #1;
        check_eq("spurious i_resp", 256'(i_mem_resp), '0);
        check_eq("spurious d_resp", 256'(d_mem_resp), '0);
        tick();

        // Read and write together: write wins
        lat_fixed = -1;
        glog.delete();
        d_mem_read = 1'b1; d_mem_write = 1'b1;
        d_mem_address = 32'h3C0; d_mem_wdata = {8{32'h0BAD_CAFE}};
        wait_resp(1'b1, d_resp_cnt + 1, 40);
        check_eq("rdwr grant", 256'(glog[0].who), 256'(W_DW));

        // Random traffic
        rand_en = 1'b1;
        repeat (3000) tick();
        rand_en = 1'b0;
        repeat (30) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
